// File: rtl/tiny8_sequencer.sv
// tiny8 control sequencer: multi-byte fetch, memory wait handshake, sticky HALT/FAULT.
// Optional memory-timeout watchdog compiled in with `define TINY8_MEM_TIMEOUT_EN.
module tiny8_sequencer #(
    parameter int FETCH_BYTES    = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          op_class,
    input  logic                branch_taken,
    input  logic                mem_resp,
    output logic                mem_read,
    output logic                mem_write,
    output logic                load_pc,
    output logic                load_acc,
    output logic                load_regfile,
    output logic                load_ir,
    output logic [((FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1)-1:0] ir_byte_sel,
    output logic                pcmux_sel,
    output logic                alumux1_sel,
    output logic                alumux2_sel,
    output logic [1:0]          addrmux_sel,
    output logic                halted,
    output logic                fault,
    output logic [2:0]          state_dbg
);
    localparam int BW = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(FETCH_BYTES - 1);

    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_HALT   = 3'd4;
    localparam logic [2:0] OP_MOV    = 3'd5;

    typedef enum logic [2:0] {
        S_FETCH1  = 3'd0,
        S_FETCH2  = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEMORY  = 3'd4,
        S_HALT    = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    state_t          state_reg, state_next;
    logic [BW-1:0]   byte_cnt_reg, byte_cnt_next;
    logic [2:0]      op_q_reg, op_q_next;
    logic            timeout;

`ifdef TINY8_MEM_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wait_reg, wait_next;
    logic          waiting;

    // A strobe is outstanding in FETCH1 and MEMORY; count only unanswered cycles.
    assign waiting   = ((state_reg == S_FETCH1) || (state_reg == S_MEMORY)) && !mem_resp;
    assign timeout   = waiting && (wait_reg == WW'(TIMEOUT_CYCLES - 1));
    assign wait_next = (waiting && !timeout) ? wait_reg + WW'(1) : '0;

    always_ff @(posedge clk) begin
        if (rst) wait_reg <= '0;
        else     wait_reg <= wait_next;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        op_q_next     = op_q_reg;
        case (state_reg)
            S_FETCH1: begin
                if (mem_resp)     state_next = S_FETCH2;
                else if (timeout) state_next = S_FAULT;
            end
            S_FETCH2: begin
                if (byte_cnt_reg == LAST_BYTE) begin
                    byte_cnt_next = '0;
                    state_next    = S_DECODE;
                end else begin
                    byte_cnt_next = byte_cnt_reg + BW'(1);
                    state_next    = S_FETCH1;
                end
            end
            S_DECODE: begin
                op_q_next = op_class;
                case (op_class)
                    OP_ALU, OP_BRANCH, OP_MOV: state_next = S_EXECUTE;
                    OP_LOAD, OP_STORE:         state_next = S_MEMORY;
                    OP_HALT:                   state_next = S_HALT;
                    default:                   state_next = S_FAULT;
                endcase
            end
            S_EXECUTE: state_next = S_FETCH1;
            S_MEMORY: begin
                if (mem_resp)     state_next = S_FETCH1;
                else if (timeout) state_next = S_FAULT;
            end
            S_HALT:  state_next = S_HALT;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_FETCH1;
            byte_cnt_reg <= '0;
            op_q_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            op_q_reg     <= op_q_next;
        end
    end

    // Outputs decode the current state; reset masks everything to 0 immediately.
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        load_pc      = 1'b0;
        load_acc     = 1'b0;
        load_regfile = 1'b0;
        load_ir      = 1'b0;
        ir_byte_sel  = '0;
        pcmux_sel    = 1'b0;
        alumux1_sel  = 1'b0;
        alumux2_sel  = 1'b0;
        addrmux_sel  = 2'd0;
        halted       = 1'b0;
        fault        = 1'b0;
        state_dbg    = 3'd0;
        if (!rst) begin
            state_dbg = state_reg;
            case (state_reg)
                S_FETCH1: mem_read = 1'b1;
                S_FETCH2: begin
                    load_ir     = 1'b1;
                    ir_byte_sel = byte_cnt_reg;
                    load_pc     = 1'b1;
                end
                S_EXECUTE: begin
                    case (op_q_reg)
                        OP_ALU:    load_acc     = 1'b1;
                        OP_MOV:    load_regfile = 1'b1;
                        OP_BRANCH: begin
                            load_pc   = branch_taken;
                            pcmux_sel = branch_taken;
                        end
                        default: ;
                    endcase
                end
                S_MEMORY: begin
                    addrmux_sel = 2'd1;
                    if (op_q_reg == OP_LOAD) begin
                        mem_read = 1'b1;
                        if (mem_resp) begin
                            load_acc    = 1'b1;
                            alumux2_sel = 1'b1;
                        end
                    end else begin
                        mem_write = 1'b1;
                    end
                end
                S_HALT:  halted = 1'b1;
                S_FAULT: fault  = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tiny8_sequencer.sv
// Directed bench for tiny8_sequencer: one FETCH_BYTES=1 instance and one
// FETCH_BYTES=3 / TIMEOUT_CYCLES=4 instance sharing clock and reset.
module tb_tiny8_sequencer;
    // Strobe vector order: {mem_read, mem_write, load_pc, load_acc, load_regfile,
    //                       load_ir, pcmux_sel, alumux1_sel, alumux2_sel, addrmux_sel[1:0]}
    localparam logic [10:0] S_NONE = 11'h000;
    localparam logic [10:0] S_F1   = 11'h400;
    localparam logic [10:0] S_F2   = 11'h120;
    localparam logic [10:0] S_ALU  = 11'h080;
    localparam logic [10:0] S_MOV  = 11'h040;
    localparam logic [10:0] S_BR   = 11'h110;
    localparam logic [10:0] S_LDW  = 11'h401;
    localparam logic [10:0] S_LDR  = 11'h485;
    localparam logic [10:0] S_ST   = 11'h201;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [2:0] op1 = 3'd0, op3 = 3'd0;
    logic       bt1 = 1'b0, bt3 = 1'b0;
    logic       resp1 = 1'b0, resp3 = 1'b0;

    logic mr1, mw1, lpc1, lacc1, lrf1, lir1, pcm1, a1m1, a2m1, h1, f1;
    logic [1:0] am1;
    logic [0:0] sel1;
    logic [2:0] sd1;
    logic mr3, mw3, lpc3, lacc3, lrf3, lir3, pcm3, a1m3, a2m3, h3, f3;
    logic [1:0] am3;
    logic [1:0] sel3;
    logic [2:0] sd3;
    logic [10:0] sig1, sig3;

    assign sig1 = {mr1, mw1, lpc1, lacc1, lrf1, lir1, pcm1, a1m1, a2m1, am1};
    assign sig3 = {mr3, mw3, lpc3, lacc3, lrf3, lir3, pcm3, a1m3, a2m3, am3};

    tiny8_sequencer #(.FETCH_BYTES(1), .TIMEOUT_CYCLES(15)) u1 (
        .clk(clk), .rst(rst), .op_class(op1), .branch_taken(bt1), .mem_resp(resp1),
        .mem_read(mr1), .mem_write(mw1), .load_pc(lpc1), .load_acc(lacc1),
        .load_regfile(lrf1), .load_ir(lir1), .ir_byte_sel(sel1), .pcmux_sel(pcm1),
        .alumux1_sel(a1m1), .alumux2_sel(a2m1), .addrmux_sel(am1),
        .halted(h1), .fault(f1), .state_dbg(sd1)
    );

    tiny8_sequencer #(.FETCH_BYTES(3), .TIMEOUT_CYCLES(4)) u3 (
        .clk(clk), .rst(rst), .op_class(op3), .branch_taken(bt3), .mem_resp(resp3),
        .mem_read(mr3), .mem_write(mw3), .load_pc(lpc3), .load_acc(lacc3),
        .load_regfile(lrf3), .load_ir(lir3), .ir_byte_sel(sel3), .pcmux_sel(pcm3),
        .alumux1_sel(a1m3), .alumux2_sel(a2m3), .addrmux_sel(am3),
        .halted(h3), .fault(f3), .state_dbg(sd3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic d1(input logic r, input logic [2:0] op, input logic bt);
        resp1 = r; op1 = op; bt1 = bt;
        #1;
    endtask

    task automatic d3(input logic r, input logic [2:0] op);
        resp3 = r; op3 = op; bt3 = 1'b0;
        #1;
    endtask

    // One reset cycle (with stray responses asserted), then return in the first free cycle.
    task automatic do_reset();
        next_cyc();
        rst = 1'b1; resp1 = 1'b1; resp3 = 1'b1;
        #1;
        chk("rst_out1", {h1, f1, sd1, sig1}, 16'h0);
        chk("rst_out3", {h3, f3, sd3, sig3, sel3}, 18'h0);
        next_cyc();
        rst = 1'b0; resp1 = 1'b0; resp3 = 1'b0;
    endtask

    initial begin
        do_reset();

        // ALU, FETCH_BYTES=1, zero wait: 4 cycles per instruction
        d1(1, 0, 0); chk("alu_c1", {sd1, sig1}, {3'd0, S_F1}); next_cyc();
        d1(0, 0, 0); chk("alu_c2", {sd1, sig1, sel1}, {3'd1, S_F2, 1'b0}); next_cyc();
        d1(0, 0, 0); chk("alu_c3", {sd1, sig1}, {3'd2, S_NONE}); next_cyc();
        d1(0, 6, 0); chk("alu_c4", {sd1, sig1}, {3'd3, S_ALU}); next_cyc();
        d1(1, 0, 0); chk("alu_c5", {sd1, sig1}, {3'd0, S_F1}); next_cyc();

        // BRANCH taken (mem_resp held high outside FETCH1 must be ignored)
        d1(1, 0, 0); chk("br1_f2", {sd1, sig1}, {3'd1, S_F2}); next_cyc();
        d1(1, 3, 0); next_cyc();
        d1(1, 0, 1); chk("br1_ex", {sd1, sig1}, {3'd3, S_BR}); next_cyc();
        // BRANCH not taken
        d1(1, 0, 0); next_cyc();
        d1(0, 0, 0); next_cyc();
        d1(0, 3, 0); next_cyc();
        d1(0, 0, 0); chk("br0_ex", {sd1, sig1}, {3'd3, S_NONE}); next_cyc();

        // MOV
        d1(1, 0, 0); next_cyc();
        d1(0, 0, 0); next_cyc();
        d1(0, 5, 0); next_cyc();
        d1(0, 0, 0); chk("mov_ex", {sd1, sig1}, {3'd3, S_MOV}); next_cyc();

        // STORE with waits, aborted by reset
        d1(1, 0, 0); next_cyc();
        d1(0, 0, 0); next_cyc();
        d1(0, 2, 0); chk("st_dec", {sd1, sig1}, {3'd2, S_NONE}); next_cyc();
        d1(0, 0, 0); chk("st_w1", {sd1, sig1}, {3'd4, S_ST}); next_cyc();
        d1(0, 0, 0); chk("st_w2", {sd1, sig1}, {3'd4, S_ST});
        do_reset();
        d1(0, 0, 0); chk("st_rst_f1", {sd1, sig1}, {3'd0, S_F1}); next_cyc();
        d1(0, 0, 0); chk("st_rst_f1b", {sd1, sig1}, {3'd0, S_F1}); next_cyc();

        // Illegal op -> sticky FAULT
        d1(1, 0, 0); next_cyc();
        d1(0, 0, 0); next_cyc();
        d1(0, 7, 0); next_cyc();
        for (int i = 0; i < 20; i++) begin
            d1(1, 3'(i), 1);
            chk("fault_hold", {f1, h1, sd1, sig1}, {1'b1, 1'b0, 3'd6, S_NONE});
            next_cyc();
        end

        // HALT after reset
        do_reset();
        d1(1, 0, 0); next_cyc();
        d1(0, 0, 0); next_cyc();
        d1(0, 4, 0); next_cyc();
        for (int i = 0; i < 5; i++) begin
            d1(1, 3'd7, 1);
            chk("halt_hold", {f1, h1, sd1, sig1}, {1'b0, 1'b1, 3'd5, S_NONE});
            next_cyc();
        end

        // FETCH_BYTES=3 LOAD, every access delayed 2 cycles: 16 cycles total
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 2; w++) begin
                d3(0, 0); chk("ld3_fwait", {sd3, sig3}, {3'd0, S_F1}); next_cyc();
            end
            d3(1, 0); chk("ld3_fresp", {sd3, sig3}, {3'd0, S_F1}); next_cyc();
            d3(0, 0); chk("ld3_f2", {sd3, sig3, sel3}, {3'd1, S_F2, 2'(k)}); next_cyc();
        end
        d3(0, 1); chk("ld3_dec", {sd3, sig3}, {3'd2, S_NONE}); next_cyc();
        for (int w = 0; w < 2; w++) begin
            d3(0, 0); chk("ld3_mwait", {sd3, sig3}, {3'd4, S_LDW}); next_cyc();
        end
        d3(1, 0); chk("ld3_mresp", {sd3, sig3}, {3'd4, S_LDR}); next_cyc();
        d3(1, 0); chk("ld3_next", {sd3, sig3}, {3'd0, S_F1}); next_cyc();
        d3(0, 0); chk("ld3_sel_wrap", {sd3, sig3, sel3}, {3'd1, S_F2, 2'd0}); next_cyc();

`ifdef TINY8_MEM_TIMEOUT_EN
        // Watchdog: mem_read for exactly 4 cycles, then FAULT
        do_reset();
        for (int w = 0; w < 4; w++) begin
            d3(0, 0); chk("to_read", {f3, sd3, sig3}, {1'b0, 3'd0, S_F1}); next_cyc();
        end
        d3(0, 0); chk("to_fault", {f3, sd3, sig3}, {1'b1, 3'd6, S_NONE}); next_cyc();
        // Response in the final allowed cycle wins
        do_reset();
        for (int w = 0; w < 3; w++) begin
            d3(0, 0); next_cyc();
        end
        d3(1, 0); chk("to_last", {f3, sd3, sig3}, {1'b0, 3'd0, S_F1}); next_cyc();
        d3(0, 0); chk("to_win", {f3, sd3, sig3}, {1'b0, 3'd1, S_F2}); next_cyc();
`else
        // No watchdog: wait indefinitely in FETCH1
        do_reset();
        for (int w = 0; w < 30; w++) begin
            d3(0, 0); chk("no_timeout", {f3, sd3, sig3}, {1'b0, 3'd0, S_F1}); next_cyc();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
